// File: rtl/cpu_pkg.sv
// Shared definitions for the 3-stage (IF/ID/EX) 16-bit CPU.
//   - pipeline controller state encodings
//   - opcode constants
//   - instruction field bit positions and a small field-extract helper
package cpu_pkg;

    // Pipeline controller states (2-bit, legacy-compatible encoding)
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Opcodes
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction field bit positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RS_MSB  = 11;
    localparam int RS_LSB  = 10;
    localparam int RT_MSB  = 9;
    localparam int RT_LSB  = 8;
    localparam int RD_MSB  = 7;
    localparam int RD_LSB  = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [1:0] rd;
        logic [7:0] imm;
    } instr_fields_t;

    function automatic instr_fields_t decode_instr(input logic [15:0] instr);
        instr_fields_t f;
        f.opcode = instr[OPC_MSB:OPC_LSB];
        f.rs     = instr[RS_MSB:RS_LSB];
        f.rt     = instr[RT_MSB:RT_LSB];
        f.rd     = instr[RD_MSB:RD_LSB];
        f.imm    = instr[IMM_MSB:IMM_LSB];
        return f;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, updated on the falling clock edge like the rest
// of the pipeline.
//   clock   : system clock (state changes on negedge)
//   reset_n : asynchronous active-low reset, clears count
//   inc     : count enable for this edge
//   count   : current value; holds at all-ones and never wraps
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the 3-stage IF/ID/EX pipeline.
// Tracks stage valid bits, gates register-file writes, selects ID-stage
// forwarding from EX, squashes wrong-path work on a taken branch, and
// drains/halts on the HALT opcode. Also keeps saturating cycle and retire
// counters. All state changes on the falling clock edge.
//   clock, reset_n                 : clock (negedge), async active-low reset
//   ifid_opcode/ifid_rs/ifid_rt    : fields of the instruction in IF/ID
//   idex_reg_write, idex_write_reg : write intent/destination of EX instr
//   branch_taken                   : EX branch resolution (needs idex_valid)
//   pc_write, pc_sel               : PC / IF-ID load enable, target select
//   ifid_valid, idex_valid         : stage valid bits
//   reg_write_en                   : regfile write enable
//   fwd_a, fwd_b                   : ID operand forwarding selects
//   state, halted                  : controller state
//   cycle_count, retire_count      : saturating performance counters
module pipeline_ctrl
    import cpu_pkg::*;
#(
    parameter logic [3:0] HALT_OP      = OP_HALT,
    parameter int         DRAIN_CYCLES = 1,
    parameter int         CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       ifid_opcode,
    input  logic [1:0]       ifid_rs,
    input  logic [1:0]       ifid_rt,
    input  logic             idex_reg_write,
    input  logic [1:0]       idex_write_reg,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             ifid_valid,
    output logic             idex_valid,
    output logic             reg_write_en,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    // drain_cnt runs 0..DRAIN_CYCLES-1; the last value triggers HALTED
    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    logic [1:0] state_q,      state_d;
    logic [2:0] drain_cnt_q,  drain_cnt_d;
    logic       ifid_valid_q, ifid_valid_d;
    logic       idex_valid_q, idex_valid_d;

    logic running;
    logic flush;
    logic halt_hit;

    // Branches and HALT are only acted on while running; once draining,
    // the front end is frozen and EX can only hold bubbles.
    assign running  = (state_q == ST_RUN);
    assign flush    = running & branch_taken & idex_valid_q;
    // A taken branch squashes the HALT sitting behind it in IF/ID.
    assign halt_hit = running & ifid_valid_q & (ifid_opcode == HALT_OP) & ~flush;

    assign pc_write = running & ~halt_hit;
    assign pc_sel   = flush;

    always_comb begin
        ifid_valid_d = pc_write & ~flush;
        // The HALT itself moves into ID/EX as a bubble.
        idex_valid_d = ifid_valid_q & ~flush & ~halt_hit;
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (halt_hit) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            drain_cnt_q  <= '0;
            ifid_valid_q <= 1'b0;
            idex_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            ifid_valid_q <= ifid_valid_d;
            idex_valid_q <= idex_valid_d;
        end
    end

    assign ifid_valid   = ifid_valid_q;
    assign idex_valid   = idex_valid_q;
    assign state        = state_q;
    assign halted       = (state_q == ST_HALTED);
    // idex_valid_q is cleared asynchronously, so a reset kills any write
    // in flight without waiting for a clock edge.
    assign reg_write_en = idex_reg_write & idex_valid_q;

    // EX result is not yet in the regfile when ID reads it; steer ALUout in.
    assign fwd_a = ifid_valid_q & idex_valid_q & idex_reg_write &
                   (idex_write_reg == ifid_rs) & ~flush;
    assign fwd_b = ifid_valid_q & idex_valid_q & idex_reg_write &
                   (idex_write_reg == ifid_rt) & ~flush;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (1'b1),
        .count   (cycle_count)
    );

    // A taken branch still retires; only its squashed followers do not,
    // and those never become valid in ID/EX.
    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (idex_valid_q),
        .count   (retire_count)
    );

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Sequencing controller for the 3-stage (IF/ID/EX) 16-bit CPU pipeline.
- Tracks per-stage valid bits and gates register-file writes with them.
- Resolves the ID/EX read-after-write race via forwarding selects, squashes wrong-path instructions on a taken branch, and drains and halts the pipeline on a HALT opcode.
- Also keeps saturating cycle and retire counters; sits beside the CPU top and drives its enables.

Parameters:
HALT_OP, 4'hF, opcode that requests halt when it reaches ID
DRAIN_CYCLES, 1, cycles spent in DRAIN before HALTED (1..7)
CNT_W, 16, width of the performance counters

Ports:
clock  in  1  system clock; all state updates on negedge clock, matching the pipeline registers
reset_n  in  1  asynchronous, active-low reset
ifid_opcode  in  4  IFID_InstrReg[15:12]
ifid_rs  in  2  IFID_InstrReg[11:10]
ifid_rt  in  2  IFID_InstrReg[9:8]
idex_reg_write  in  1  RegWrite latched in ID/EX
idex_write_reg  in  2  destination register selected in EX (rt/rd mux output)
branch_taken  in  1  EX-stage branch resolution; ignored unless idex_valid
pc_write  out  1  PC and IFID_InstrReg load enable
pc_sel  out  1  1 = load branch target, 0 = PC+1
ifid_valid  out  1  IF/ID holds a real instruction
idex_valid  out  1  ID/EX holds a real instruction
reg_write_en  out  1  regfile write enable = idex_reg_write & idex_valid
fwd_a  out  1  ID operand A takes EX ALUout instead of ReadData1
fwd_b  out  1  ID operand B takes EX ALUout instead of ReadData2
state  out  2  0 RUN, 1 DRAIN, 2 HALTED
halted  out  1  state == HALTED
cycle_count  out  CNT_W  negedges since reset, saturating
retire_count  out  CNT_W  valid instructions leaving EX, saturating

Behaviour:
- Reset, asserted asynchronously:
  - state=RUN, ifid_valid=0, idex_valid=0, drain_cnt=0, cycle_count=0, retire_count=0.
  - Combinational outputs then follow: pc_write=1, pc_sel=0, reg_write_en=0, fwd_a=fwd_b=0, halted=0.
  - Deassertion is honoured at the next negedge.
- Pipeline fill: the first negedge after reset sets ifid_valid=1. The next sets idex_valid=1. The first real EX result is 2 negedges after reset release.
- Per negedge in RUN:
  - ifid_valid <= pc_write & ~flush
  - idex_valid <= ifid_valid & ~flush & ~halt_hit
  - flush = branch_taken & idex_valid
  - halt_hit = ifid_valid & (ifid_opcode==HALT_OP) & ~flush
- Taken branch:
  - Combinationally, pc_sel=1 and pc_write=1 in the same cycle.
  - At the negedge both IF/ID and ID/EX go invalid, giving a 2-bubble penalty.
  - Branch wins over a simultaneous halt_hit; the HALT is squashed and state stays RUN.
- Halt:
  - halt_hit moves RUN->DRAIN. The HALT itself enters ID/EX as a bubble.
  - pc_write=0 combinationally in the halt_hit cycle and in all later cycles until reset.
  - DRAIN counts DRAIN_CYCLES negedges (drain_cnt), then moves to HALTED.
  - branch_taken is ignored in DRAIN and HALTED.
  - HALTED: all valids 0, pc_write=0, reg_write_en=0, cycle_count still counts. Only reset exits.
- Forwarding (combinational):
  - fwd_a = ifid_valid & idex_valid & idex_reg_write & (idex_write_reg==ifid_rs).
  - fwd_b is the same with ifid_rt.
  - Both may be 1 at once.
  - Both are forced 0 when flush=1.
- Counters:
  - cycle_count increments every negedge.
  - retire_count increments when idex_valid & ~flush-squashed-self. A taken branch does retire; its squashed followers do not.
  - Both hold at 2^CNT_W-1 and never wrap.
- Reset mid-operation (including during DRAIN) returns immediately to the reset values above. No partial writes: reg_write_en drops asynchronously.

Decomposition:
- Shared package cpu_pkg holds:
  - state encodings ST_RUN=2'd0, ST_DRAIN=2'd1, ST_HALTED=2'd2.
  - opcode constants, including OP_HALT=4'hF.
  - instruction field bit positions (opcode 15:12, rs 11:10, rt 9:8, rd 7:6, imm 7:0).
- One sub-module, sat_counter (parameter W; ports clock, reset_n, inc, count), instantiated twice for the performance counters.

Test Plan:
- Reset release with a stream of 4 ADDs:
  - ifid_valid rises at negedge 1 and idex_valid at negedge 2.
  - reg_write_en is 0 before negedge 2.
  - After 6 negedges: cycle_count=6, retire_count=4.
- Back-to-back dependency:
  - Setup: ID/EX valid with idex_write_reg=2'd1, idex_reg_write=1; IF/ID valid with rs=1, rt=1.
  - Check fwd_a=1, fwd_b=1.
  - With idex_reg_write=0, both are 0.
- branch_taken=1 while idex_valid=1:
  - pc_sel=1 that cycle.
  - Next negedge: ifid_valid=0, idex_valid=0, fwd_a=fwd_b=0.
  - retire_count increments by 1 for the branch only.
- HALT (4'hF) in ID with DRAIN_CYCLES=1:
  - pc_write=0 immediately.
  - state: DRAIN after 1 negedge, HALTED after 2.
  - halted=1 and reg_write_en stays 0 for 10 more cycles.
- HALT in ID together with branch_taken=1: state stays RUN, pc_write=1, pc_sel=1, halted never asserts.
- reset_n pulsed low mid-clock during DRAIN: outputs take reset values without waiting for a clock edge; the counters read 0.
